// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI pins and backing-memory read port of the flash responder.
interface spi_flash_responder_if #(
    parameter int ADDR_W = 20
);
    logic              SPI_CS;
    logic              SPI_SCK;
    logic              SPI_SI;
    logic              SPI_SO;
    logic              SPI_SO_oe;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;

    modport master (
        output SPI_CS, SPI_SCK, SPI_SI, mem_rdata,
        input  SPI_SO, SPI_SO_oe, mem_rd_en, mem_addr
    );

    modport slave (
        input  SPI_CS, SPI_SCK, SPI_SI, mem_rdata,
        output SPI_SO, SPI_SO_oe, mem_rd_en, mem_addr
    );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: oversampled SPI flash emulator answering wake-up (0xAB) and read (0x03) from a byte ROM/RAM.
// Define SPI_RESPONDER_FAST_READ_EN to also accept fast read (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
    parameter int          ADDR_W      = 20,
    parameter logic [23:0] BASE_ADDR   = 24'h050000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  resetn,
    spi_flash_responder_if.slave  bus,
    output logic                  powered_down,
    output logic                  busy,
    output logic [7:0]            last_opcode
);
    localparam logic [2:0] IDLE = 3'd0, CMD = 3'd1, ADDR = 3'd2, DATA = 3'd3, IGNORE = 3'd4;
`ifdef SPI_RESPONDER_FAST_READ_EN
    localparam logic [2:0] DUMMY = 3'd5;
    logic fast_q, fast_d;
`endif

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d, si_sync_q, si_sync_d;
    logic              cs_prev_q, cs_prev_d, sck_prev_q, sck_prev_d;
    logic [2:0]        state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [22:0]       shift_q, shift_d;
    logic [23:0]       flash_addr_q, flash_addr_d;
    logic [7:0]        so_sr_q, so_sr_d, hold_q, hold_d, last_op_q, last_op_d;
    logic              skip_q, skip_d, oe_q, oe_d, mem_rd_en_q, mem_rd_en_d, pd_q, pd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        fetch_q, fetch_d;
    logic              fetch_win_q, fetch_win_d, fetch_first_q, fetch_first_d;
    logic              cs, sck, si, cs_rise, cs_fall, sck_rise, sck_fall;
    logic              start, first, win;
    logic [23:0]       next_addr, off;
    logic [7:0]        rx_byte, fetched;

    assign cs       = cs_sync_q[SYNC_STAGES-1];
    assign sck      = sck_sync_q[SYNC_STAGES-1];
    assign si       = si_sync_q[SYNC_STAGES-1];
    assign cs_rise  = cs & ~cs_prev_q;
    assign cs_fall  = ~cs & cs_prev_q;
    assign sck_rise = ~cs & sck & ~sck_prev_q;
    assign sck_fall = ~cs & ~sck & sck_prev_q;
    assign rx_byte  = {shift_q[6:0], si};
    assign fetched  = fetch_win_q ? bus.mem_rdata : 8'hFF;

    assign bus.SPI_SO    = so_sr_q[7];
    assign bus.SPI_SO_oe = oe_q;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign powered_down  = pd_q;
    assign busy          = state_q != IDLE;
    assign last_opcode   = last_op_q;

    always_comb begin
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], bus.SPI_CS};
        sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], bus.SPI_SCK};
        si_sync_d     = {si_sync_q[SYNC_STAGES-2:0], bus.SPI_SI};
        cs_prev_d     = cs;
        sck_prev_d    = sck;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        flash_addr_d  = flash_addr_q;
        so_sr_d       = so_sr_q;
        hold_d        = hold_q;
        skip_d        = skip_q;
        oe_d          = oe_q;
        mem_rd_en_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        fetch_d       = {fetch_q[0], 1'b0};
        fetch_win_d   = fetch_win_q;
        fetch_first_d = fetch_first_q;
        pd_d          = pd_q;
        last_op_d     = last_op_q;
        start         = 1'b0;
        first         = 1'b0;
        next_addr     = flash_addr_q;
`ifdef SPI_RESPONDER_FAST_READ_EN
        fast_d        = fast_q;
`endif
        // Read data lands one CLK after the strobe; first byte goes straight to the shifter.
        if (fetch_q[1]) begin
            if (fetch_first_q) begin
                so_sr_d = fetched;
                oe_d    = 1'b1;
            end else
                hold_d  = fetched;
        end
        case (state_q)
            IDLE: if (cs_fall) begin
                state_d   = CMD;
                bit_cnt_d = '0;
            end
            CMD: if (sck_rise) begin
                shift_d   = {shift_q[21:0], si};
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd7) begin
                    last_op_d = rx_byte;
                    bit_cnt_d = '0;
                    state_d   = IGNORE;
                    if (rx_byte == 8'hAB) pd_d = 1'b0;
                    else if (!pd_q && rx_byte == 8'h03) state_d = ADDR;
`ifdef SPI_RESPONDER_FAST_READ_EN
                    fast_d = rx_byte == 8'h0B;
                    if (!pd_q && rx_byte == 8'h0B) state_d = ADDR;
`endif
                end
            end
            ADDR: if (sck_rise) begin
                shift_d   = {shift_q[21:0], si};
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd23) begin
                    flash_addr_d = {shift_q, si};
                    next_addr    = {shift_q, si};
                    bit_cnt_d    = '0;
                    start        = 1'b1;
                    first        = 1'b1;
`ifdef SPI_RESPONDER_FAST_READ_EN
                    if (fast_q) begin
                        start   = 1'b0;
                        first   = 1'b0;
                        state_d = DUMMY;
                    end
`endif
                end
            end
`ifdef SPI_RESPONDER_FAST_READ_EN
            DUMMY: if (sck_rise) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                start     = bit_cnt_q == 5'd7;
                first     = bit_cnt_q == 5'd7;
            end
`endif
            // The fall right after the last command/dummy rise only arms the shifter.
            DATA: if (sck_fall) begin
                if (skip_q)
                    skip_d = 1'b0;
                else if (bit_cnt_q == 5'd7) begin
                    so_sr_d   = hold_q;
                    bit_cnt_d = '0;
                end else begin
                    so_sr_d   = {so_sr_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd6) begin
                        next_addr    = flash_addr_q + 24'd1;
                        flash_addr_d = flash_addr_q + 24'd1;
                        start        = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        off = next_addr - BASE_ADDR;
        win = (next_addr >= BASE_ADDR) && ({1'b0, off} < (25'd1 << ADDR_W));
        if (start) begin
            mem_rd_en_d   = win;
            mem_addr_d    = win ? off[ADDR_W-1:0] : mem_addr_q;
            fetch_d[0]    = 1'b1;
            fetch_win_d   = win;
            fetch_first_d = first;
            if (first) begin
                state_d   = DATA;
                skip_d    = 1'b1;
                bit_cnt_d = '0;
            end
        end
        if (cs_rise) begin
            state_d     = IDLE;
            oe_d        = 1'b0;
            bit_cnt_d   = '0;
            skip_d      = 1'b0;
            mem_rd_en_d = 1'b0;
            fetch_d     = '0;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            cs_sync_q     <= '1;
            sck_sync_q    <= '0;
            si_sync_q     <= '0;
            cs_prev_q     <= 1'b1;
            sck_prev_q    <= 1'b0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            flash_addr_q  <= '0;
            so_sr_q       <= '0;
            hold_q        <= '0;
            skip_q        <= 1'b0;
            oe_q          <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            fetch_q       <= '0;
            fetch_win_q   <= 1'b0;
            fetch_first_q <= 1'b0;
            pd_q          <= 1'b1;
            last_op_q     <= 8'h00;
`ifdef SPI_RESPONDER_FAST_READ_EN
            fast_q        <= 1'b0;
`endif
        end else begin
            cs_sync_q     <= cs_sync_d;
            sck_sync_q    <= sck_sync_d;
            si_sync_q     <= si_sync_d;
            cs_prev_q     <= cs_prev_d;
            sck_prev_q    <= sck_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            flash_addr_q  <= flash_addr_d;
            so_sr_q       <= so_sr_d;
            hold_q        <= hold_d;
            skip_q        <= skip_d;
            oe_q          <= oe_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            fetch_q       <= fetch_d;
            fetch_win_q   <= fetch_win_d;
            fetch_first_q <= fetch_first_d;
            pd_q          <= pd_d;
            last_op_q     <= last_op_d;
`ifdef SPI_RESPONDER_FAST_READ_EN
            fast_q        <= fast_d;
`endif
        end
    end
endmodule
